// File: rtl/alu_pkg.sv
// Shared mALU definitions used by the sequential divider.
package alu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div_state_e;

    localparam int unsigned DIV_WIDTH = 8;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/alu_seq_divider_if.sv
// Start/valid handshake and result bus between ALU control and the divider.
interface alu_seq_divider_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic             iStart;
    logic [WIDTH-1:0] iDividend;
    logic [WIDTH-1:0] iDivisor;
    logic             oBusy;
    logic             oValid;
    logic [WIDTH-1:0] oQuotient;
    logic [WIDTH-1:0] oRemainder;
    logic             oDivByZero;
    logic             ZeroFlag;

    modport master (
        output iStart, iDividend, iDivisor,
        input  oBusy, oValid, oQuotient, oRemainder, oDivByZero, ZeroFlag
    );

    modport slave (
        input  iStart, iDividend, iDivisor,
        output oBusy, oValid, oQuotient, oRemainder, oDivByZero, ZeroFlag
    );

endinterface

// File: rtl/div_trial_sub.sv
// Ripple-borrow trial subtractor: diff_o = s_i - d_i, borrow_o set when s_i < d_i.
module div_trial_sub #(
    parameter int unsigned Width = 9
) (
    input  logic [Width-1:0] s_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] diff_o,
    output logic             borrow_o
);

    logic [Width:0] b;

    assign b[0] = 1'b0;

    for (genvar i = 0; i < Width; i++) begin : g_stage
        assign diff_o[i] = s_i[i] ^ d_i[i] ^ b[i];
        assign b[i+1]    = (~s_i[i] & d_i[i]) | (~(s_i[i] ^ d_i[i]) & b[i]);
    end

    assign borrow_o = b[Width];

endmodule

// File: rtl/alu_seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/valid handshake.
module alu_seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 3
) (
    input logic              iClk,
    input logic              iRst_n,
    alu_seq_divider_if.slave bus
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_quot_q, res_quot_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;

    // Partial remainder is one bit wider so the shifted value (up to 2*D-1) never overflows.
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    div_trial_sub #(
        .Width (WIDTH + 1)
    ) u_trial_sub (
        .s_i      (shifted),
        .d_i      ({1'b0, div_q}),
        .diff_o   (trial),
        .borrow_o (borrow)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;
        dbz_d      = dbz_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.iStart) begin
                    if (bus.iDivisor != '0) begin
                        rem_d   = '0;
                        quo_d   = bus.iDividend;
                        div_d   = bus.iDivisor;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        res_quot_d = WIDTH'(DIV0_QUOT);
                        res_rem_d  = bus.iDividend;
                        dbz_d      = 1'b1;
                        valid_d    = 1'b1;
                        state_d    = StDone;
                    end
                end
            end
            StBusy: begin
                rem_d = borrow ? shifted : trial;
                quo_d = {quo_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_quot_d = quo_d;
                    res_rem_d  = rem_d[WIDTH-1:0];
                    dbz_d      = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            res_quot_q <= '0;
            res_rem_q  <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            dbz_q      <= dbz_d;
        end
    end

    // A kept remainder is always below the divisor, so its top bit stays clear.
    rem_msb_clear: assert property (@(posedge iClk) disable iff (!iRst_n) rem_q[WIDTH] == 1'b0);

    assign bus.oBusy      = busy_q;
    assign bus.oValid     = valid_q;
    assign bus.oQuotient  = res_quot_q;
    assign bus.oRemainder = res_rem_q;
    assign bus.oDivByZero = dbz_q;
    assign bus.ZeroFlag   = (res_quot_q == '0);

endmodule
